// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller: issues one request per memop, waits for ack or timeout, registers writeback.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_MEM,
   input  logic        DM_w_MEM,
   input  logic        write_MEM,
   input  logic [4:0]  waddr_MEM,
   input  logic [1:0]  mux_wdata_MEM,
   input  logic [31:0] alu_MEM,
   input  logic [31:0] npc_MEM,
   input  logic [31:0] DM_wdata_MEM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic        write_WB,
   output logic [4:0]  waddr_WB,
   output logic [31:0] wdata_WB,
   output logic        mem_err,
   output logic        misalign
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          write_wb_q, write_wb_d;
   logic [4:0]    waddr_wb_q, waddr_wb_d;
   logic [31:0]   wdata_wb_q, wdata_wb_d;
   logic          err_q, err_d;
   logic          misalign_q, misalign_d;
   logic          memop;
   logic          mis_access;

   assign memop = valid_MEM & (DM_w_MEM | (mux_wdata_MEM == 2'b01));

`ifdef MEM_ALIGN_CHECK_EN
   assign mis_access = memop & (alu_MEM[1:0] != 2'b00);
`else
   assign mis_access = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_wb_q <= 1'b0;
         waddr_wb_q <= '0;
         wdata_wb_q <= '0;
         err_q      <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         write_wb_q <= write_wb_d;
         waddr_wb_q <= waddr_wb_d;
         wdata_wb_q <= wdata_wb_d;
         err_q      <= err_d;
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      write_wb_d = 1'b0;
      waddr_wb_d = waddr_wb_q;
      wdata_wb_d = wdata_wb_q;
      err_d      = err_q;
      misalign_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mis_access) begin
               misalign_d = 1'b1;
               state_d    = S_DONE;
            end else if (memop) begin
               addr_d  = {alu_MEM[31:2], 2'b00};
               we_d    = DM_w_MEM;
               wdata_d = DM_wdata_MEM;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               write_wb_d = valid_MEM & write_MEM;
               waddr_wb_d = waddr_MEM;
               wdata_wb_d = (mux_wdata_MEM == 2'b10) ? npc_MEM : alu_MEM;
            end
         end
         S_WAIT: begin
            // Ack is tested first so it wins over a simultaneous timeout.
            if (mem_ack) begin
               req_d   = 1'b0;
               state_d = S_DONE;
               if (!we_q) begin
                  write_wb_d = write_MEM;
                  waddr_wb_d = waddr_MEM;
                  wdata_wb_d = mem_rdata;
               end
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign stall     = ((state_q == S_IDLE) & memop & ~mis_access) | (state_q == S_WAIT);
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign write_WB  = write_wb_q;
   assign waddr_WB  = waddr_wb_q;
   assign wdata_WB  = wdata_wb_q;
   assign mem_err   = err_q;
   assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: each instruction is checked against a transaction-level model
// (expected request, stall length, writeback and sticky error derived from the ack delay).
module tb_mem_access_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_MEM, DM_w_MEM, write_MEM;
   logic [4:0]  waddr_MEM;
   logic [1:0]  mux_wdata_MEM;
   logic [31:0] alu_MEM, npc_MEM, DM_wdata_MEM;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        stall, write_WB, mem_err, misalign;
   logic [4:0]  waddr_WB;
   logic [31:0] wdata_WB;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_txn    = 0;
   logic err_exp  = 1'b0;

   mem_access_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .valid_MEM(valid_MEM), .DM_w_MEM(DM_w_MEM), .write_MEM(write_MEM),
      .waddr_MEM(waddr_MEM), .mux_wdata_MEM(mux_wdata_MEM),
      .alu_MEM(alu_MEM), .npc_MEM(npc_MEM), .DM_wdata_MEM(DM_wdata_MEM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
      .write_WB(write_WB), .waddr_WB(waddr_WB), .wdata_WB(wdata_WB),
      .mem_err(mem_err), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge where the next instruction may be applied.
   task automatic do_instr(input logic v, input logic dmw, input logic wr, input logic [4:0] wa,
                           input logic [1:0] mux, input logic [31:0] alu, input logic [31:0] npc,
                           input logic [31:0] sd, input int d, input logic [31:0] rd);
      logic memop, mis, tmo, wb_exp;
      int   waits;
      memop = v & (dmw | (mux == 2'b01));
      mis   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis = memop & (alu[1:0] != 2'b00);
`endif
      valid_MEM = v; DM_w_MEM = dmw; write_MEM = wr; waddr_MEM = wa; mux_wdata_MEM = mux;
      alu_MEM = alu; npc_MEM = npc; DM_wdata_MEM = sd;
      mem_ack = !memop && ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      #1 check("stall_issue", 32'(stall), 32'(memop & !mis));
      tmo = 1'b0;
      if (!memop) begin
         @(negedge clk);
         mem_ack = 1'b0;
         wb_exp = v & wr;
         check("alu_write_WB", 32'(write_WB), 32'(wb_exp));
         if (wb_exp) begin
            check("alu_waddr_WB", 32'(waddr_WB), 32'(wa));
            check("alu_wdata_WB", wdata_WB, (mux == 2'b10) ? npc : alu);
         end
         check("alu_mem_req", 32'(mem_req), 32'd0);
      end else if (mis) begin
         @(negedge clk);
         check("mis_pulse", 32'(misalign), 32'd1);
         check("mis_mem_req", 32'(mem_req), 32'd0);
         check("mis_write_WB", 32'(write_WB), 32'd0);
         check("mis_stall", 32'(stall), 32'd0);
         @(negedge clk);
         check("mis_pulse_end", 32'(misalign), 32'd0);
         check("mis_write_WB2", 32'(write_WB), 32'd0);
      end else begin
         tmo   = (d >= TO);
         waits = tmo ? TO : d + 1;
         for (int k = 0; k < waits; k++) begin
            @(negedge clk);
            check("wait_mem_req", 32'(mem_req), 32'd1);
            check("wait_stall", 32'(stall), 32'd1);
            check("wait_write_WB", 32'(write_WB), 32'd0);
            if (k == 0) begin
               check("mem_addr", mem_addr, {alu[31:2], 2'b00});
               check("mem_we", 32'(mem_we), 32'(dmw));
               check("mem_wdata", mem_wdata, sd);
            end
            mem_ack   = (k == d);
            mem_rdata = (k == d) ? rd : $urandom;
         end
         @(negedge clk);
         mem_ack   = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         if (tmo) err_exp = 1'b1;
         wb_exp = !dmw & wr & !tmo;
         check("done_mem_req", 32'(mem_req), 32'd0);
         check("done_stall", 32'(stall), 32'd0);
         check("done_write_WB", 32'(write_WB), 32'(wb_exp));
         if (wb_exp) begin
            check("load_waddr_WB", 32'(waddr_WB), 32'(wa));
            check("load_wdata_WB", wdata_WB, rd);
         end
         check("done_mem_err", 32'(mem_err), 32'(err_exp));
         @(negedge clk);
         mem_ack = 1'b0;
         check("post_write_WB", 32'(write_WB), 32'd0);
         check("post_mem_req", 32'(mem_req), 32'd0);
      end
`ifndef MEM_ALIGN_CHECK_EN
      check("misalign_tied", 32'(misalign), 32'd0);
`endif
      n_txn++;
      $display("txn %0d: v=%0b st=%0b wr=%0b mux=%0d wa=%0d alu=%08h ack_delay=%0d memop=%0b mis=%0b tmo=%0b",
               n_txn, v, dmw, wr, mux, wa, alu, d, memop, mis, tmo);
   endtask

   initial begin
      rst = 1'b1;
      valid_MEM = 0; DM_w_MEM = 0; write_MEM = 0; waddr_MEM = 0; mux_wdata_MEM = 0;
      alu_MEM = 0; npc_MEM = 0; DM_wdata_MEM = 0; mem_ack = 0; mem_rdata = 0;
      #1;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_write_WB", 32'(write_WB), 32'd0);
      check("rst_mem_err", 32'(mem_err), 32'd0);
      check("rst_misalign", 32'(misalign), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_wdata_WB", wdata_WB, 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      do_instr(1, 0, 1, 5'd5, 2'b00, 32'h1234, 32'h0, 32'h0, 0, 32'h0);
      do_instr(1, 0, 1, 5'd8, 2'b01, 32'h100, 32'h0, 32'h0, 3, 32'hDEADBEEF);
      do_instr(1, 1, 0, 5'd0, 2'b00, 32'h204, 32'h0, 32'hA5A5A5A5, 0, 32'h0);
      do_instr(1, 0, 1, 5'd7, 2'b10, 32'h55, 32'h0000_1000, 32'h0, 0, 32'h0);
      do_instr(1, 0, 1, 5'd3, 2'b01, 32'h40, 32'h0, 32'h0, 100, 32'h0);
      do_instr(1, 0, 1, 5'd4, 2'b11, 32'h77, 32'h0, 32'h0, 0, 32'h0);
      do_instr(1, 0, 1, 5'd9, 2'b01, 32'h102, 32'h0, 32'h0, 1, 32'h12345678);

      // Reset in the middle of a load, then a stray ack.
      valid_MEM = 1; DM_w_MEM = 0; write_MEM = 1; waddr_MEM = 5'd12; mux_wdata_MEM = 2'b01;
      alu_MEM = 32'h300;
      @(negedge clk);
      check("rstwait_req_before", 32'(mem_req), 32'd1);
      rst = 1'b1;
      valid_MEM = 1'b0;
      err_exp = 1'b0;
      #1;
      check("rstwait_mem_req", 32'(mem_req), 32'd0);
      check("rstwait_stall", 32'(stall), 32'd0);
      check("rstwait_mem_err", 32'(mem_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      mem_ack = 1'b0;
      check("rstwait_ack_req", 32'(mem_req), 32'd0);
      check("rstwait_ack_wb", 32'(write_WB), 32'd0);
      @(negedge clk);
      check("rstwait_ack_wb2", 32'(write_WB), 32'd0);
      $display("txn %0d: reset during WAIT followed by stray ack", ++n_txn);

      for (int i = 0; i < 150; i++) begin
         logic        v, dmw, wr;
         logic [4:0]  wa;
         logic [1:0]  mux;
         logic [31:0] alu, npc, sd, rd;
         int          d;
         v   = ($urandom_range(0, 5) != 0);
         dmw = ($urandom_range(0, 3) == 0);
         wr  = 1'($urandom_range(0, 1)) | !dmw;
         wa  = 5'($urandom);
         mux = 2'($urandom);
         alu = $urandom;
         npc = $urandom;
         sd  = $urandom;
         rd  = $urandom;
         d   = int'($urandom_range(0, 6));
         do_instr(v, dmw, wr, wa, mux, alu, npc, sd, d, rd);
      end

      valid_MEM = 1'b0;
      @(negedge clk);
      check("final_mem_err", 32'(mem_err), 32'(err_exp));
      check("final_mem_req", 32'(mem_req), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
